twi_slave_logic: RTL and testbench

TWI_SLAVE_LOGIC -- requirements
Module: twi_slave_logic

---
 rtl/twi_pkg.sv | 22 ++
 rtl/twi_line_filter.sv | 50 +++++
 rtl/twi_slave_logic.sv | 186 ++++++++++++++++++
 tb/tb_twi_slave_logic.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/twi_pkg.sv
// Shared types and constants for the TWI slave: FSM states, bus field widths
// and the SDA levels that mean ACK and NACK.
package twi_pkg;

    localparam int unsigned AddrW = 7;
    localparam int unsigned DataW = 8;

    localparam logic AckLvl  = 1'b0;
    localparam logic NackLvl = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StRx,
        StRxAck,
        StTx,
        StTxAck,
        StIgnore
    } twiState_e;

endpackage

// File: rtl/twi_line_filter.sv
// One bus line: 2-FF synchronizer, FILTER_LEN-sample glitch filter and registered
// rise/fall pulses that are asserted in the same cycle the filtered level changes.
module twi_line_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic iClk,
    input  logic iReset,
    input  logic iLine,
    output logic oLevel,
    output logic oRise,
    output logic oFall
);

    localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic            sync1Q, sync2Q, levelQ, riseQ, fallQ;
    logic [CntW-1:0] cntQ;

    always_ff @(posedge iClk) begin
        if (iReset) begin
            sync1Q <= 1'b1;
            sync2Q <= 1'b1;
            levelQ <= 1'b1;
            cntQ   <= '0;
            riseQ  <= 1'b0;
            fallQ  <= 1'b0;
        end else begin
            sync1Q <= iLine;
            sync2Q <= sync1Q;
            riseQ  <= 1'b0;
            fallQ  <= 1'b0;
            // cntQ counts consecutive samples that disagree with the filtered level.
            if (sync2Q == levelQ) begin
                cntQ <= '0;
            end else if (cntQ == CntW'(FILTER_LEN - 1)) begin
                cntQ   <= '0;
                levelQ <= sync2Q;
                riseQ  <= sync2Q;
                fallQ  <= ~sync2Q;
            end else begin
                cntQ <= cntQ + 1'b1;
            end
        end
    end

    assign oLevel = levelQ;
    assign oRise  = riseQ;
    assign oFall  = fallQ;

endmodule

// File: rtl/twi_slave_logic.sv
// Byte-level TWI (I2C) slave. Define TWI_SLAVE_GENERAL_CALL_EN to also accept
// general-call writes (address 7'h00, R/W=0).
module twi_slave_logic
    import twi_pkg::*;
#(
    parameter logic [AddrW-1:0] SLAVE_ADDR = 7'h5F,
    parameter int unsigned      FILTER_LEN = 4
) (
    input  logic             iPlbClk,
    input  logic             iPlbReset,
    input  logic             iScl,
    input  logic             iSda,
    output logic             oSda,
    output logic             oStart,
    output logic             oStop,
    output logic [DataW-1:0] oRxData,
    output logic             oRxValid,
    input  logic             iRxAck,
    output logic             oTxReq,
    input  logic [DataW-1:0] iTxData
);

    logic sclLevel, sclRise, sclFall, sdaLevel, sdaRise, sdaFall;

    twi_line_filter #(.FILTER_LEN(FILTER_LEN)) uSclFilter (
        .iClk   (iPlbClk),
        .iReset (iPlbReset),
        .iLine  (iScl),
        .oLevel (sclLevel),
        .oRise  (sclRise),
        .oFall  (sclFall)
    );

    twi_line_filter #(.FILTER_LEN(FILTER_LEN)) uSdaFilter (
        .iClk   (iPlbClk),
        .iReset (iPlbReset),
        .iLine  (iSda),
        .oLevel (sdaLevel),
        .oRise  (sdaRise),
        .oFall  (sdaFall)
    );

    twiState_e        stateQ, stateD;
    logic [2:0]       bitCntQ, bitCntD;
    logic [DataW-1:0] shiftQ, shiftD, txShiftQ, txShiftD, rxDataQ, rxDataD;
    logic             rwQ, rwD, ackQ, ackD, sdaQ, sdaD;
    logic             startQ, startD, stopQ, stopD, rxValidQ, rxValidD;
    logic             txReqQ, txReqD, txLoadQ;
    logic             startDet, stopDet, addrHit;
    logic [DataW-1:0] rxByte;

    assign startDet = sdaFall & sclLevel;
    assign stopDet  = sdaRise & sclLevel;
    assign rxByte   = {shiftQ[DataW-2:0], sdaLevel};

`ifdef TWI_SLAVE_GENERAL_CALL_EN
    assign addrHit = (rxByte[7:1] == SLAVE_ADDR) || (rxByte[7:1] == '0 && !rxByte[0]);
`else
    assign addrHit = (rxByte[7:1] == SLAVE_ADDR);
`endif

    always_ff @(posedge iPlbClk) begin
        if (iPlbReset) begin
            stateQ   <= StIdle;
            bitCntQ  <= '0;
            shiftQ   <= '0;
            txShiftQ <= '0;
            rxDataQ  <= '0;
            rwQ      <= 1'b0;
            ackQ     <= 1'b0;
            sdaQ     <= NackLvl;
            startQ   <= 1'b0;
            stopQ    <= 1'b0;
            rxValidQ <= 1'b0;
            txReqQ   <= 1'b0;
            txLoadQ  <= 1'b0;
        end else begin
            stateQ   <= stateD;
            bitCntQ  <= bitCntD;
            shiftQ   <= shiftD;
            txShiftQ <= txShiftD;
            rxDataQ  <= rxDataD;
            rwQ      <= rwD;
            ackQ     <= ackD;
            sdaQ     <= sdaD;
            startQ   <= startD;
            stopQ    <= stopD;
            rxValidQ <= rxValidD;
            txReqQ   <= txReqD;
            txLoadQ  <= txReqQ;
        end
    end

    always_comb begin
        stateD   = stateQ;
        bitCntD  = bitCntQ;
        shiftD   = shiftQ;
        txShiftD = txShiftQ;
        rxDataD  = rxDataQ;
        rwD      = rwQ;
        ackD     = ackQ;
        sdaD     = sdaQ;
        startD   = 1'b0;
        stopD    = 1'b0;
        rxValidD = 1'b0;
        txReqD   = 1'b0;

        if (txLoadQ) txShiftD = iTxData;
        // iRxAck is taken while oRxValid is visible to the user.
        if (stateQ == StRxAck && rxValidQ) ackD = iRxAck;

        if (startDet) begin
            startD  = 1'b1;
            bitCntD = '0;
            stateD  = StAddr;
        end else if (stopDet) begin
            stopD  = 1'b1;
            sdaD   = NackLvl;
            stateD = StIdle;
        end else if (sclRise) begin
            unique case (stateQ)
                StAddr: begin
                    shiftD  = rxByte;
                    bitCntD = bitCntQ + 3'd1;
                    if (bitCntQ == 3'd7) begin
                        rwD    = rxByte[0];
                        stateD = addrHit ? StAddrAck : StIgnore;
                    end
                end
                StAddrAck: begin
                    bitCntD = '0;
                    if (rwQ) begin
                        txReqD = 1'b1;
                        stateD = StTx;
                    end else begin
                        stateD = StRx;
                    end
                end
                StRx: begin
                    shiftD  = rxByte;
                    bitCntD = bitCntQ + 3'd1;
                    if (bitCntQ == 3'd7) begin
                        rxDataD  = rxByte;
                        rxValidD = 1'b1;
                        stateD   = StRxAck;
                    end
                end
                StRxAck: begin
                    bitCntD = '0;
                    stateD  = ackQ ? StRx : StIgnore;
                end
                StTx: begin
                    txShiftD = {txShiftQ[DataW-2:0], 1'b0};
                    bitCntD  = bitCntQ + 3'd1;
                    if (bitCntQ == 3'd7) stateD = StTxAck;
                end
                StTxAck: begin
                    bitCntD = '0;
                    if (sdaLevel == AckLvl) begin
                        txReqD = 1'b1;
                        stateD = StTx;
                    end else begin
                        stateD = StIgnore;
                    end
                end
                default: ;
            endcase
        end else if (sclFall) begin
            // SDA only moves while SCL is low, one cycle after the filtered fall.
            unique case (stateQ)
                StAddrAck: sdaD = AckLvl;
                StRxAck:   sdaD = ackQ ? AckLvl : NackLvl;
                StTx:      sdaD = txShiftQ[DataW-1];
                default:   sdaD = NackLvl;
            endcase
        end
    end

    assign oSda     = sdaQ;
    assign oStart   = startQ;
    assign oStop    = stopQ;
    assign oRxData  = rxDataQ;
    assign oRxValid = rxValidQ;
    assign oTxReq   = txReqQ;

endmodule

// File: tb/tb_twi_slave_logic.sv
// Self-checking bench for twi_slave_logic: bus master tasks with a wired-AND SDA,
// directed scenarios plus randomized frames scored against a transaction-level model.
module tb_twi_slave_logic;
    import twi_pkg::*;

    localparam int H = 12;  // SCL half period in clocks

    logic       clk = 1'b0;
    logic       rst, scl, mSda, iRxAck, iSda;
    logic [7:0] iTxData = 8'h00;
    logic       oSda, oStart, oStop, oRxValid, oTxReq;
    logic [7:0] oRxData;

    assign iSda = mSda & oSda;

    twi_slave_logic #(.SLAVE_ADDR(7'h5F), .FILTER_LEN(4)) dut (
        .iPlbClk   (clk),
        .iPlbReset (rst),
        .iScl      (scl),
        .iSda      (iSda),
        .oSda      (oSda),
        .oStart    (oStart),
        .oStop     (oStop),
        .oRxData   (oRxData),
        .oRxValid  (oRxValid),
        .iRxAck    (iRxAck),
        .oTxReq    (oTxReq),
        .iTxData   (iTxData)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int nStart = 0, nStop = 0, nRxValid = 0, nTxReq = 0, sdaLowCnt = 0;
    logic [7:0] lastRx = 8'h00;
    logic [7:0] txBytes [64];

    // Event monitor; also serves iTxData on the cycle after each oTxReq.
    always @(negedge clk) begin
        if (oStart) nStart++;
        if (oStop) nStop++;
        if (oRxValid) begin
            nRxValid++;
            lastRx = oRxData;
        end
        if (oTxReq) begin
            iTxData = txBytes[nTxReq % 64];
            nTxReq++;
        end
        if (!oSda) sdaLowCnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SCL period starting and ending with SCL low; s is the bus SDA seen while high.
    task automatic clkBit(input logic b, output logic s);
        cyc(H / 2); mSda = b;
        cyc(H / 2); scl = 1'b1;
        cyc(H / 2); s = iSda;
        cyc(H / 2); scl = 1'b0;
    endtask

    task automatic startCond();
        if (!scl) begin
            cyc(H / 2); mSda = 1'b1;
            cyc(H / 2); scl = 1'b1;
        end
        cyc(H / 2); mSda = 1'b0;
        cyc(H / 2); scl = 1'b0;
    endtask

    task automatic stopCond();
        cyc(H / 2); mSda = 1'b0;
        cyc(H / 2); scl = 1'b1;
        cyc(H / 2); mSda = 1'b1;
        cyc(H);
    endtask

    task automatic writeByte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clkBit(d[i], s);
        clkBit(1'b1, ack);
    endtask

    task automatic readByte(input logic masterAck, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clkBit(1'b1, s);
            d[i] = s;
        end
        clkBit(!masterAck, s);
    endtask

    initial begin
        logic       a1, a2, a3, s;
        logic [7:0] d;
        int         b0, b1, b2, b3;
        logic [7:0] rdExp [6];

        scl = 1'b1; mSda = 1'b1; rst = 1'b1; iRxAck = 1'b1;
        cyc(3);
        check("rst_sda", oSda, 1);
        check("rst_start", oStart, 0);
        check("rst_stop", oStop, 0);
        check("rst_rxvalid", oRxValid, 0);
        check("rst_txreq", oTxReq, 0);
        check("rst_rxdata", oRxData, 8'h00);
        check("rst_state", dut.stateQ, StIdle);
        rst = 1'b0;
        cyc(10);

        // Write frame to own address
        b0 = nRxValid; b1 = nStop; b2 = nStart;
        startCond();
        writeByte(8'hBE, a1);
        writeByte(8'hEF, a2);
        stopCond();
        check("wr_addr_ack", a1, 0);
        check("wr_data_ack", a2, 0);
        check("wr_rxvalid_cnt", nRxValid - b0, 1);
        check("wr_rxdata", lastRx, 8'hEF);
        check("wr_stop_cnt", nStop - b1, 1);
        check("wr_start_cnt", nStart - b2, 1);

        // Foreign address: slave never touches SDA
        b0 = nRxValid; b1 = sdaLowCnt;
        startCond();
        writeByte(8'h78, a1);
        writeByte(8'h4A, a2);
        stopCond();
        check("nm_addr_nack", a1, 1);
        check("nm_data_nack", a2, 1);
        check("nm_sda_low", sdaLowCnt - b1, 0);
        check("nm_rxvalid_cnt", nRxValid - b0, 0);

        // Single-byte read, master NACK
        b0 = nTxReq;
        txBytes[b0 % 64] = 8'h6E;
        startCond();
        writeByte(8'hBF, a1);
        readByte(1'b0, d);
        check("rd_addr_ack", a1, 0);
        check("rd_byte", d, 8'h6E);
        check("rd_txreq_cnt", nTxReq - b0, 1);
        check("rd_ignore", dut.stateQ, StIgnore);
        b1 = sdaLowCnt;
        cyc(2 * H);
        stopCond();
        check("rd_ignore_sda", sdaLowCnt - b1, 0);
        check("rd_idle", dut.stateQ, StIdle);

        // Write then repeated START and a 6-byte read
        rdExp = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5};
        b0 = nTxReq; b1 = nStart;
        for (int i = 0; i < 6; i++) txBytes[(b0 + i) % 64] = rdExp[i];
        startCond();
        writeByte(8'hBE, a1);
        writeByte(8'hA6, a2);
        startCond();
        writeByte(8'hBF, a3);
        check("rs_wr_ack", a1, 0);
        check("rs_data_ack", a2, 0);
        check("rs_rxdata", lastRx, 8'hA6);
        check("rs_rd_ack", a3, 0);
        for (int i = 0; i < 6; i++) begin
            readByte(i < 5, d);
            check($sformatf("rs_byte%0d", i), d, rdExp[i]);
        end
        stopCond();
        check("rs_start_cnt", nStart - b1, 2);
        check("rs_txreq_cnt", nTxReq - b0, 6);

        // Short SCL glitch between address bits
        b0 = nRxValid;
        startCond();
        clkBit(1'b1, s); clkBit(1'b0, s); clkBit(1'b1, s);
        check("gl_bits_before", dut.bitCntQ, 3);
        cyc(H / 2); scl = 1'b1; cyc(2); scl = 1'b0;
        cyc(H);
        check("gl_bits_after", dut.bitCntQ, 3);
        clkBit(1'b1, s); clkBit(1'b1, s); clkBit(1'b1, s); clkBit(1'b1, s); clkBit(1'b0, s);
        clkBit(1'b1, a1);
        check("gl_addr_ack", a1, 0);
        writeByte(8'h11, a2);
        stopCond();
        check("gl_data_ack", a2, 0);
        check("gl_rxdata", lastRx, 8'h11);
        check("gl_rxvalid_cnt", nRxValid - b0, 1);

        // Reset while the slave holds the address ACK
        startCond();
        for (int i = 7; i >= 0; i--) clkBit(8'hBE >> i, s);
        cyc(10);
        check("ra_sda_ack", oSda, 0);
        check("ra_state", dut.stateQ, StAddrAck);
        rst = 1'b1;
        cyc(1);
        check("ra_sda_rel", oSda, 1);
        check("ra_idle", dut.stateQ, StIdle);
        rst = 1'b0;
        cyc(10);
        stopCond();
        cyc(10);

        // Randomized frames against the transaction model
        for (int f = 0; f < 10; f++) begin
            int   nb;
            logic hit, live, ackSel, isRead;
            logic [6:0] addr;
            logic [7:0] data;
            hit    = 1'($urandom_range(0, 1));
            isRead = hit && ($urandom_range(0, 2) == 0);
            addr   = 7'($urandom_range(1, 127));
            if (addr == 7'h5F) addr = 7'h21;
            if (hit) addr = 7'h5F;
            nb = $urandom_range(1, 3);
            if (isRead) begin
                b0 = nTxReq;
                for (int i = 0; i < nb; i++) txBytes[(b0 + i) % 64] = 8'($urandom);
                startCond();
                writeByte({addr, 1'b1}, a1);
                check("rnd_rd_addr_ack", a1, 0);
                for (int i = 0; i < nb; i++) begin
                    readByte(i < nb - 1, d);
                    check("rnd_rd_byte", d, txBytes[(b0 + i) % 64]);
                end
                stopCond();
                check("rnd_rd_txreq_cnt", nTxReq - b0, nb);
            end else begin
                live = hit;
                startCond();
                writeByte({addr, 1'b0}, a1);
                check("rnd_wr_addr_ack", a1, hit ? 0 : 1);
                for (int i = 0; i < nb; i++) begin
                    data   = 8'($urandom);
                    ackSel = 1'($urandom_range(0, 1));
                    iRxAck = ackSel;
                    b0 = nRxValid;
                    writeByte(data, a2);
                    check("rnd_wr_data_ack", a2, (live && ackSel) ? 0 : 1);
                    check("rnd_wr_rxvalid_cnt", nRxValid - b0, live ? 1 : 0);
                    if (live) check("rnd_wr_rxdata", lastRx, data);
                    live = live && ackSel;
                end
                stopCond();
                iRxAck = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
